// File: rtl/scanout_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : scanout_sequencer
// Description : Display scan-out controller for a 1-bit video RAM. Walks the
//               frame in raster order, drives the RAM read address with
//               {row, col}, and delays blank/sync timing by the RAM's one-cycle
//               read latency so that video, hsync and vsync leave aligned.
//
// Ports
//   clk          in   1   pixel clock (only clock)
//   rst          in   1   asynchronous active-high reset
//   enable       in   1   run scan-out; low holds the scan at the frame origin
//   raddr        out  32  RAM read address, [31:16] = row, [15:0] = col
//   rdata        in   1   RAM read data, valid one clock after raddr
//   video        out  1   pixel output, 0 outside the active area
//   hsync        out  1   horizontal sync, asserted at HSYNC_POL
//   vsync        out  1   vertical sync, asserted at VSYNC_POL
//   frame_start  out  1   one-cycle pulse aligned with output pixel (0,0)
//
// Revision    : 1.0  initial release
// ============================================================================
module scanout_sequencer #(
    parameter int   H_ACTIVE  = 720,
    parameter int   H_FP      = 10,
    parameter int   H_SYNC    = 135,
    parameter int   H_BP      = 17,
    parameter int   V_ACTIVE  = 350,
    parameter int   V_FP      = 3,
    parameter int   V_SYNC    = 16,
    parameter int   V_BP      = 1,
    parameter logic HSYNC_POL = 1'b1,
    parameter logic VSYNC_POL = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    output logic [31:0] raddr,
    input  logic        rdata,
    output logic        video,
    output logic        hsync,
    output logic        vsync,
    output logic        frame_start
);

    localparam int c_H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int c_V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Last counter values; totals are at most 65536 so these fit 16 bits.
    localparam logic [15:0] c_H_LAST = 16'(c_H_TOTAL - 1);
    localparam logic [15:0] c_V_LAST = 16'(c_V_TOTAL - 1);

    // Region bounds may reach 65536, so compare in 17 bits.
    localparam logic [16:0] c_H_ACT_END  = 17'(H_ACTIVE);
    localparam logic [16:0] c_HS_BEGIN   = 17'(H_ACTIVE + H_FP);
    localparam logic [16:0] c_HS_END     = 17'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [16:0] c_V_ACT_END  = 17'(V_ACTIVE);
    localparam logic [16:0] c_VS_BEGIN   = 17'(V_ACTIVE + V_FP);
    localparam logic [16:0] c_VS_END     = 17'(V_ACTIVE + V_FP + V_SYNC);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [15:0] h_q, h_d;
    logic [15:0] v_q, v_d;

    // Stage 1: timing flags captured alongside the RAM read
    logic active_d1_q, active_d1_d;
    logic hreg_d1_q,   hreg_d1_d;
    logic vreg_d1_q,   vreg_d1_d;
    logic origin_d1_q, origin_d1_d;
    logic enable_d1_q, enable_d1_d;

    // Stage 2: registered outputs
    logic video_q,       video_d;
    logic hsync_q,       hsync_d;
    logic vsync_q,       vsync_d;
    logic frame_start_q, frame_start_d;

    logic [16:0] w_h_ext;
    logic [16:0] w_v_ext;
    logic        w_active;
    logic        w_hreg;
    logic        w_vreg;
    logic        w_origin;

    assign w_h_ext = {1'b0, h_q};
    assign w_v_ext = {1'b0, v_q};

    // Region decode of the position currently being read from RAM
    assign w_active = (w_h_ext < c_H_ACT_END) && (w_v_ext < c_V_ACT_END);
    assign w_hreg   = (w_h_ext >= c_HS_BEGIN) && (w_h_ext < c_HS_END);
    assign w_vreg   = (w_v_ext >= c_VS_BEGIN) && (w_v_ext < c_VS_END);
    assign w_origin = (h_q == 16'd0) && (v_q == 16'd0);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (!enable) begin
            h_d = 16'd0;
            v_d = 16'd0;
        end else if (h_q == c_H_LAST) begin
            h_d = 16'd0;
            v_d = (v_q == c_V_LAST) ? 16'd0 : v_q + 16'd1;
        end else begin
            h_d = h_q + 16'd1;
        end
    end

    // While disabled the counters sit at the origin, which would otherwise
    // decode as active/origin; gate the flags so the pipeline goes idle.
    always_comb begin
        active_d1_d = enable & w_active;
        hreg_d1_d   = enable & w_hreg;
        vreg_d1_d   = enable & w_vreg;
        origin_d1_d = enable & w_origin;
        enable_d1_d = enable;
    end

    // rdata here is the RAM word for the position whose flags sit in stage 1
    always_comb begin
        video_d       = rdata & active_d1_q;
        hsync_d       = hreg_d1_q ? HSYNC_POL : ~HSYNC_POL;
        vsync_d       = vreg_d1_q ? VSYNC_POL : ~VSYNC_POL;
        frame_start_d = origin_d1_q & enable_d1_q;
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_q           <= 16'd0;
            v_q           <= 16'd0;
            active_d1_q   <= 1'b0;
            hreg_d1_q     <= 1'b0;
            vreg_d1_q     <= 1'b0;
            origin_d1_q   <= 1'b0;
            enable_d1_q   <= 1'b0;
            video_q       <= 1'b0;
            hsync_q       <= ~HSYNC_POL;
            vsync_q       <= ~VSYNC_POL;
            frame_start_q <= 1'b0;
        end else begin
            h_q           <= h_d;
            v_q           <= v_d;
            active_d1_q   <= active_d1_d;
            hreg_d1_q     <= hreg_d1_d;
            vreg_d1_q     <= vreg_d1_d;
            origin_d1_q   <= origin_d1_d;
            enable_d1_q   <= enable_d1_d;
            video_q       <= video_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            frame_start_q <= frame_start_d;
        end
    end

    // Address comes straight from the counter flops, so it never glitches
    assign raddr       = {v_q, h_q};
    assign video       = video_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign frame_start = frame_start_q;

endmodule
`default_nettype wire

// File: tb/tb_scanout_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_scanout_sequencer
// Description : Self-checking bench for scanout_sequencer with small timing
//               (H 8/2/3/1, V 4/1/2/1). A reference model tracks the linear
//               pixel index within the frame and derives every output from it.
// Revision    : 1.0  initial release
// ============================================================================
module tb_scanout_sequencer;

    localparam int c_HT = 14;
    localparam int c_VT = 8;
    localparam int c_FT = c_HT * c_VT;

    logic        clk;
    logic        rst;
    logic        enable;
    logic [31:0] raddr;
    logic        rdata;
    logic        video;
    logic        hsync;
    logic        vsync;
    logic        frame_start;

    int n_chk  = 0;
    int n_pass = 0;

    bit ram [0:c_FT-1];

    scanout_sequencer #(
        .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (1),
        .V_ACTIVE (4), .V_FP (1), .V_SYNC (2), .V_BP (1),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b0)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .raddr      (raddr),
        .rdata      (rdata),
        .video      (video),
        .hsync      (hsync),
        .vsync      (vsync),
        .frame_start(frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Video RAM with one-clock read latency
    always @(posedge clk) begin
        if (int'(raddr[31:16]) < c_VT && int'(raddr[15:0]) < c_HT)
            rdata <= ram[int'(raddr[31:16]) * c_HT + int'(raddr[15:0])];
        else
            rdata <= 1'b0;
    end

    // Reference model: m_pos is the linear index the scan is presenting;
    // m_last is what was sampled at the latest edge (-1 = idle), m_src the
    // one before, which is what the outputs show now.
    int m_pos, m_last, m_src;
    bit m_last_bit, m_src_bit;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pos      <= 0;
            m_last     <= -1;
            m_src      <= -1;
            m_last_bit <= 1'b0;
            m_src_bit  <= 1'b0;
        end else begin
            m_src      <= m_last;
            m_src_bit  <= m_last_bit;
            m_last     <= enable ? m_pos : -1;
            m_last_bit <= ram[m_pos];
            m_pos      <= enable ? (m_pos + 1) % c_FT : 0;
        end
    end

    // Expected {video, hsync, vsync, frame_start} for a sampled position
    function automatic logic [3:0] exp_out(input int p, input bit rb);
        int row, col;
        logic act, hs, vs;
        if (p < 0) return 4'b0010;
        row = p / c_HT;
        col = p % c_HT;
        act = (col < 8) && (row < 4);
        hs  = (col >= 10) && (col < 13);
        vs  = (row >= 5) && (row < 7);
        return {act & rb, hs, ~vs, (p == 0)};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Advance one clock and compare everything against the model
    task automatic step();
        logic [31:0] ea;
        @(negedge clk);
        ea = {16'(m_pos / c_HT), 16'(m_pos % c_HT)};
        check("raddr", raddr, ea);
        check("outs", {28'd0, video, hsync, vsync, frame_start},
              {28'd0, exp_out(m_src, m_src_bit)});
    endtask

    int cnt_h, cnt_vl, cnt_vid, cnt_fs, fs_vid, n;

    initial begin
        rst    = 1'b0;
        enable = 1'b1;
        for (int i = 0; i < c_FT; i++) ram[i] = bit'($urandom_range(0, 1));

        // Async reset before any clock edge
        #1 rst = 1'b1;
        #1;
        check("rst_raddr", raddr, 32'd0);
        check("rst_outs", {28'd0, video, hsync, vsync, frame_start}, 32'h2);
        repeat (3) step();
        rst = 1'b0;

        // Free run across two frames
        repeat (2 * c_FT + 20) step();

        // Frame statistics with an all-ones RAM
        for (int i = 0; i < c_FT; i++) ram[i] = 1'b1;
        repeat (3) step();
        cnt_h = 0; cnt_vl = 0; cnt_vid = 0; cnt_fs = 0; fs_vid = 0;
        for (int i = 0; i < c_FT; i++) begin
            step();
            cnt_h   += int'(hsync);
            cnt_vl  += int'(!vsync);
            cnt_vid += int'(video);
            cnt_fs  += int'(frame_start);
            if (frame_start && video) fs_vid++;
        end
        check("hsync_cnt", cnt_h, 32'd24);
        check("vsync_low_cnt", cnt_vl, 32'd28);
        check("video_cnt", cnt_vid, 32'd32);
        check("fs_cnt", cnt_fs, 32'd1);
        check("fs_with_video", fs_vid, 32'd1);

        // Drop enable at row 2, col 5
        n = 0;
        while (m_pos != 2 * c_HT + 5 && n < 200) begin step(); n++; end
        check("drop_found", 32'(m_pos == 2 * c_HT + 5), 32'd1);
        check("drop_pos", raddr, 32'h0002_0005);
        enable = 1'b0;
        step();
        check("drop_raddr", raddr, 32'd0);
        step();
        step();
        check("drop_idle", {28'd0, video, hsync, vsync, frame_start}, 32'h2);
        enable = 1'b1;
        n = 0;
        do begin step(); n++; end while (!frame_start && n < 10);
        check("reen_fs_lat", n, 32'd2);

        // Randomised enable and RAM contents
        for (int i = 0; i < c_FT; i++) ram[i] = bit'($urandom_range(0, 1));
        for (int i = 0; i < 600; i++) begin
            enable = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 3) == 0)
                ram[$urandom_range(0, c_FT - 1)] = bit'($urandom_range(0, 1));
            step();
        end

        // Async reset mid-frame, between clock edges
        enable = 1'b1;
        for (int i = 0; i < c_FT; i++) ram[i] = 1'b1;
        n = 0;
        while (m_pos != 3 * c_HT + 4 && n < 300) begin step(); n++; end
        check("mid_found", 32'(m_pos == 3 * c_HT + 4), 32'd1);
        check("mid_video_pre", {31'd0, video}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_raddr", raddr, 32'd0);
        check("mid_rst_outs", {28'd0, video, hsync, vsync, frame_start}, 32'h2);
        step();
        rst = 1'b0;
        repeat (c_FT + 10) step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/scanout_sequencer.md
# scanout_sequencer

Display scan-out controller that sequences the read port of the 1-bit video RAM. It walks every pixel of the frame in raster order and drives the RAM read address with {row, col}. It delays the blank and sync timing to match the RAM's one-cycle read latency, so the monitor receives aligned `video`, `hsync` and `vsync`. It sits between the video RAM read port and the monitor output pins.

## Interface

Parameters (defaults are MDA 720x350 timing):
- `H_ACTIVE`, 720, visible pixels per line
- `H_FP`, 10, horizontal front porch (pixels)
- `H_SYNC`, 135, horizontal sync width (pixels)
- `H_BP`, 17, horizontal back porch (pixels); H_TOTAL = 882
- `V_ACTIVE`, 350, visible lines per frame
- `V_FP`, 3, vertical front porch (lines)
- `V_SYNC`, 16, vertical sync width (lines)
- `V_BP`, 1, vertical back porch (lines); V_TOTAL = 370
- `HSYNC_POL`, 1, asserted level of `hsync`
- `VSYNC_POL`, 0, asserted level of `vsync`
- Constraints: every parameter is ≥1, H_TOTAL ≤ 65536 and V_TOTAL ≤ 65536.

Ports:
- `clk`  in  1  pixel clock; the only clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `enable`  in  1  run scan-out; low holds the scan at the frame origin.
- `raddr`  out  32  video RAM read address: [31:16] = row (v counter), [15:0] = col (h counter).
- `rdata`  in  1  video RAM read data; valid one clock after `raddr`.
- `video`  out  1  pixel output, forced to 0 outside the active area.
- `hsync`  out  1  horizontal sync at `HSYNC_POL`.
- `vsync`  out  1  vertical sync at `VSYNC_POL`.
- `frame_start`  out  1  one-cycle pulse aligned with output pixel (0,0).

## Operation

- Counters: `h` is 16 bits and runs 0..H_TOTAL-1. `v` is 16 bits and runs 0..V_TOTAL-1.
- `h` increments every clock while `enable` is high.
- When `h` = H_TOTAL-1, `h` wraps to 0 and `v` increments. When `v` = V_TOTAL-1 at the same time, `v` also wraps to 0.
- Horizontal segment order: active [0, H_ACTIVE), front porch, sync, back porch. Vertical segments use the same order.
- Sync regions:
  - hsync region is h ∈ [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
  - vsync region is v ∈ [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC), covering whole lines regardless of `h`.
- Active region is h < H_ACTIVE and v < V_ACTIVE.
- `raddr` = {v, h}, driven directly from the counter registers, so it is glitch-free. It tracks the counters during blanking too; blanking is masked downstream, not by the address.
- Stage 1 registers active, hsync-region, vsync-region and origin (h=0, v=0) alongside the RAM read.
- Stage 2 registers the outputs:
  - `video` = rdata & active_d1
  - `hsync` = hreg_d1 ? HSYNC_POL : ~HSYNC_POL
  - `vsync` likewise, using VSYNC_POL
  - `frame_start` = origin_d1 & enable_d1
- `enable` low:
  - Counters are loaded to (0,0) synchronously.
  - Stage-1 flags are loaded inactive, so outputs are idle within 2 clocks.
- `enable` rising: the first counted position is (0,0) on the cycle `enable` is first sampled high.

## Timing

- Latency: counter state at edge n appears on `video`/`hsync`/`vsync`/`frame_start` after edge n+2, i.e. a fixed 2-clock pipeline. The RAM read provides 1 of those clocks, stage 2 the other.
- `raddr` changes 0 clocks after the counters, since it is the counters.
- Reset (async, immediate, no clock needed):
  - h = v = 0 and `raddr` = 0.
  - Stage-1 flags inactive.
  - `video` = 0, `hsync` = ~HSYNC_POL, `vsync` = ~VSYNC_POL, `frame_start` = 0.
- Reset deassertion with `enable` high: counting starts on the first clock edge. The first `frame_start` appears 2 clocks after the counters show (0,0).
- Reset mid-frame: outputs go to reset values immediately. No partial line completes.
- Periods: `hsync` is asserted for exactly H_SYNC clocks every H_TOTAL. `vsync` is asserted for V_SYNC·H_TOTAL clocks every H_TOTAL·V_TOTAL.
- `enable` dropped mid-line: counters are (0,0) after the next edge. Already-issued pipeline contents drain, up to 2 more valid output cycles, then outputs are idle.

## Test plan

Benches use small parameters: H 8/2/3/1 (H_TOTAL 14), V 4/1/2/1 (V_TOTAL 8), HSYNC_POL=1, VSYNC_POL=0, with a RAM model that has 1-clock latency.

1. Release reset with `enable`=1 → `raddr` sequence is 0x0, 0x1 … 0xD, then 0x00010000. After 0x00070000 + 0xD it wraps to 0x0 (frame = 112 clocks).
2. Check hsync → `hsync`=1 for exactly 3 clocks, starting 2 clocks after `raddr` col=10, repeating every 14 clocks.
3. Check vsync → `vsync`=0 for exactly 28 consecutive clocks (rows 5–6, delayed by 2), repeating every 112 clocks.
4. RAM model returns 1 for every address → `video`=1 for exactly 8 clocks per line on 4 lines (32 clocks per frame), 0 elsewhere. `frame_start` pulses once per 112 clocks, coincident with the first `video`=1.
5. Drop `enable` at row 2, col 5 → `raddr`=0 after the next edge. Outputs are idle within 2 clocks. Re-enable gives `frame_start` exactly 2 clocks after `raddr`=0 is first counted.
6. Assert `rst` mid-frame between clock edges → `video`=0, `hsync`=0, `vsync`=1, `raddr`=0 immediately, with no clock edge required.
